// File: rtl/fifo_rr_drain_arbiter.sv
// fifo_rr_drain_arbiter
//   Drains NUM_REQ registered-read FIFOs into one valid/ready consumer.
//   Eligible (enabled and non-empty) sources are picked round-robin; each pop
//   is a single-cycle rd_en pulse, the entry is captured one cycle later and
//   held on the output until accepted. Up to BURST_LEN back-to-back pops are
//   taken from one source before the pointer rotates past it.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_mask_i        per-source enable
//   fifo_empty_i      per-source empty flag
//   fifo_rd_en_o      per-source read pulse (one-hot or zero)
//   fifo_rd_data_i    packed read data, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid_o       output entry valid
//   out_ready_i       consumer accepts the entry
//   out_data_o        popped entry
//   out_src_o         source index of the popped entry
//   grant_cnt_o       completed handshakes, wraps at 2^16
module fifo_rr_drain_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              cfg_mask_i,
    input  logic [NUM_REQ-1:0]              fifo_empty_i,
    output logic [NUM_REQ-1:0]              fifo_rd_en_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   fifo_rd_data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic [$clog2(NUM_REQ)-1:0]      out_src_o,
    output logic [15:0]                     grant_cnt_o
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);
    localparam int unsigned BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [1:0]            state_q, state_d;
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [SRC_W-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]    fifo_rd_en_q, fifo_rd_en_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SRC_W-1:0]      out_src_q, out_src_d;
    logic [15:0]           grant_cnt_q, grant_cnt_d;

    logic [NUM_REQ-1:0]    elig_c;
    logic [SRC_W-1:0]      pick_c;

    assign elig_c = cfg_mask_i & ~fifo_empty_i;

    // Round-robin pick: scan offsets high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        int unsigned idx;
        pick_c = '0;
        idx    = 0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            idx = (32'(rr_ptr_q) + i - 1) % NUM_REQ;
            if (elig_c[idx]) begin
                pick_c = SRC_W'(idx);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        grant_d      = grant_q;
        fifo_rd_en_d = '0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        grant_cnt_d  = grant_cnt_q;

        case (state_q)
            ST_ARB: begin
                if (elig_c != '0) begin
                    grant_d      = pick_c;
                    burst_cnt_d  = '0;
                    fifo_rd_en_d = ONE_HOT0 << pick_c;
                    state_d      = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // FIFO read data is valid this cycle (one-cycle read latency).
                out_data_d  = fifo_rd_data_i[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                out_src_d   = grant_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    grant_cnt_d = grant_cnt_q + 16'd1;
                    // fifo_empty_i already reflects the pop, so elig tells whether another entry exists.
                    if ((32'(burst_cnt_q) < BURST_LEN - 1) && elig_c[grant_q]) begin
                        burst_cnt_d  = burst_cnt_q + BC_W'(1);
                        fifo_rd_en_d = ONE_HOT0 << grant_q;
                        state_d      = ST_RD;
                    end else begin
                        rr_ptr_d = (grant_q == SRC_W'(NUM_REQ - 1)) ? '0 : grant_q + SRC_W'(1);
                        state_d  = ST_ARB;
                    end
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARB;
            rr_ptr_q     <= '0;
            burst_cnt_q  <= '0;
            grant_q      <= '0;
            fifo_rd_en_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            grant_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            grant_q      <= grant_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            grant_cnt_q  <= grant_cnt_d;
        end
    end

    assign fifo_rd_en_o = fifo_rd_en_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_src_o    = out_src_q;
    assign grant_cnt_o  = grant_cnt_q;

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Directed bench for fifo_rr_drain_arbiter with behavioural source FIFOs and
// a queue of expected (source, data) entries checked at each handshake.
module tb_fifo_rr_drain_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   cfg_mask = '1;
    logic [NR-1:0]   fifo_empty = '1;
    logic [NR-1:0]   rd_en;
    logic [NR*DW-1:0] rd_bus = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic [15:0]     grant_cnt;

    logic [NR-1:0]   wr_en = '0;
    logic [DW-1:0]   wr_dat [NR];
    logic            clr = 1'b0;
    logic [DW-1:0]   fq [NR][$];
    logic [65:0]     sb [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_rr_drain_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mask_i(cfg_mask), .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(rd_en), .fifo_rd_data_i(rd_bus), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_src_o(out_src),
        .grant_cnt_o(grant_cnt)
    );

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural sync FIFOs: registered read data, empty updated after the edge.
    always @(posedge clk) begin
        for (int k = 0; k < NR; k++) begin
            if (clr) begin
                fq[k].delete();
            end else begin
                if (rd_en[k]) begin
                    chk("rd_on_nonempty", 66'(fq[k].size() != 0), 66'(1));
                    if (fq[k].size() != 0) rd_bus[k*DW +: DW] <= fq[k].pop_front();
                end
                if (wr_en[k]) fq[k].push_back(wr_dat[k]);
            end
            fifo_empty[k] <= (fq[k].size() == 0);
        end
    end

    // Handshake monitor: every accepted entry must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) chk("rd_en_onehot0", 66'($onehot0(rd_en)), 66'(1));
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_entry", {out_src, out_data}, 66'h3_dead_dead_dead_dead);
            end else begin
                chk("entry_src_data", {out_src, out_data}, sb.pop_front());
            end
        end
    end

    function automatic logic [DW-1:0] mk(input int src, input int n);
        return DW'(64'hA000_0000_0000_0000) | DW'(src << 8) | DW'(n);
    endfunction

    task automatic push(input int k, input logic [DW-1:0] d);
        wr_en[k]  = 1'b1;
        wr_dat[k] = d;
        @(posedge clk);
        #1 wr_en[k] = 1'b0;
    endtask

    task automatic expect_entry(input int src, input logic [DW-1:0] d);
        sb.push_back({2'(src), d});
    endtask

    // Holds reset and empties the FIFOs; caller preloads, then calls release_rst.
    task automatic hold_rst;
        @(negedge clk);
        rst_n = 1'b0;
        clr   = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic release_rst;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget, input logic [NR-1:0] never_rd);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            @(negedge clk);
            chk({tag, "_no_rd"}, 66'(rd_en & never_rd), 66'(0));
            n++;
        end
        repeat (6) begin
            @(negedge clk);
            chk({tag, "_no_rd"}, 66'(rd_en & never_rd), 66'(0));
        end
        chk({tag, "_drained"}, 66'(sb.size()), 66'(0));
    endtask

    initial begin
        logic [DW-1:0] held_data;
        logic [1:0]    held_src;
        int            n;

        for (int k = 0; k < NR; k++) wr_dat[k] = '0;

        // Reset values.
        hold_rst();
        #1;
        chk("rst_valid", 66'(out_valid), 66'(0));
        chk("rst_rd_en", 66'(rd_en), 66'(0));
        chk("rst_data",  66'(out_data), 66'(0));
        chk("rst_src",   66'(out_src), 66'(0));
        chk("rst_cnt",   66'(grant_cnt), 66'(0));

        // 1: one entry per FIFO, full mask -> 0,1,2,3 with 3-cycle first latency.
        cfg_mask = 4'hF;
        for (int k = 0; k < NR; k++) begin
            push(k, mk(k, 0));
            expect_entry(k, mk(k, 0));
        end
        release_rst();
        @(negedge clk); chk("t1_lat_c1", 66'(out_valid), 66'(0));
        @(negedge clk); chk("t1_lat_c2", 66'(out_valid), 66'(0));
        @(negedge clk); chk("t1_lat_c3", 66'(out_valid), 66'(1));
        drain("t1", 60, '0);
        chk("t1_cnt", 66'(grant_cnt), 66'(4));

        // 2: FIFO1 holds A,B,C -> burst of two, re-arbitrate, then C.
        hold_rst();
        for (int i = 0; i < 3; i++) begin
            push(1, mk(1, 10 + i));
            expect_entry(1, mk(1, 10 + i));
        end
        release_rst();
        drain("t2", 60, 4'b1101);
        chk("t2_cnt", 66'(grant_cnt), 66'(3));

        // 3: FIFO0 and FIFO2 hold three each -> 0,0,2,2,0,2.
        hold_rst();
        for (int i = 0; i < 3; i++) begin
            push(0, mk(0, 20 + i));
            push(2, mk(2, 20 + i));
        end
        expect_entry(0, mk(0, 20)); expect_entry(0, mk(0, 21));
        expect_entry(2, mk(2, 20)); expect_entry(2, mk(2, 21));
        expect_entry(0, mk(0, 22)); expect_entry(2, mk(2, 22));
        release_rst();
        drain("t3", 80, 4'b1010);
        chk("t3_cnt", 66'(grant_cnt), 66'(6));

        // 4: consumer stalls for 10 cycles in OUT -> output held, no reads, count frozen.
        hold_rst();
        out_ready = 1'b0;
        push(0, mk(0, 30)); push(0, mk(0, 31));
        expect_entry(0, mk(0, 30)); expect_entry(0, mk(0, 31));
        release_rst();
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_valid_seen", 66'(out_valid), 66'(1));
        held_data = out_data;
        held_src  = out_src;
        chk("t4_first_data", 66'(held_data), 66'(mk(0, 30)));
        repeat (10) begin
            @(negedge clk);
            chk("t4_hold_valid", 66'(out_valid), 66'(1));
            chk("t4_hold_data_src", {out_src, out_data}, {held_src, held_data});
            chk("t4_no_rd", 66'(rd_en), 66'(0));
            chk("t4_cnt_frozen", 66'(grant_cnt), 66'(0));
        end
        out_ready = 1'b1;
        drain("t4", 40, '0);
        chk("t4_cnt", 66'(grant_cnt), 66'(2));

        // 5a: mask 1011 with every FIFO non-empty -> source 2 untouched.
        hold_rst();
        cfg_mask = 4'b1011;
        for (int k = 0; k < NR; k++) push(k, mk(k, 40));
        expect_entry(0, mk(0, 40)); expect_entry(1, mk(1, 40)); expect_entry(3, mk(3, 40));
        release_rst();
        drain("t5a", 60, 4'b0100);
        chk("t5a_fifo2_kept", 66'(fq[2].size()), 66'(1));
        chk("t5a_cnt", 66'(grant_cnt), 66'(3));

        // 5b: clear mask bit 0 while FIFO0 is being read -> that entry still delivered, no more from 0.
        hold_rst();
        cfg_mask = 4'b1011;
        push(0, mk(0, 50)); push(0, mk(0, 51)); push(0, mk(0, 52));
        push(1, mk(1, 50));
        expect_entry(0, mk(0, 50)); expect_entry(1, mk(1, 50));
        release_rst();
        n = 0;
        while (!rd_en[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5b_rd0_seen", 66'(rd_en), 66'(4'b0001));
        cfg_mask = 4'b1010;
        drain("t5b", 60, 4'b0101);
        chk("t5b_fifo0_left", 66'(fq[0].size()), 66'(2));
        chk("t5b_cnt", 66'(grant_cnt), 66'(2));

        // 6: reset while in WAIT -> outputs clear at once, entry dropped, count stays 0.
        hold_rst();
        cfg_mask = 4'hF;
        push(0, mk(0, 60));
        release_rst();
        n = 0;
        while (!rd_en[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_rd0_seen", 66'(rd_en), 66'(4'b0001));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 66'(out_valid), 66'(0));
        chk("t6_rst_rd_en", 66'(rd_en), 66'(0));
        chk("t6_rst_data_src", {out_src, out_data}, 66'(0));
        chk("t6_rst_cnt", 66'(grant_cnt), 66'(0));
        release_rst();
        repeat (12) begin
            @(negedge clk);
            chk("t6_no_valid", 66'(out_valid), 66'(0));
        end
        chk("t6_cnt", 66'(grant_cnt), 66'(0));
        chk("t6_sb_empty", 66'(sb.size()), 66'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
